spi_pwm_cfg_ctrl: RTL and testbench

SPI-slave configuration controller for the PWM peripheral. It receives 16-bit write frames from an external SPI master and maintains the five configuration registers that drive `pwm_peripheral`: output enables, PWM enables and duty cycle. It sits between the chip's dedicated inputs and `pwm_peripheral`, and replaces the constant ties on those five buses.

---
 rtl/spi_pwm_cfg_ctrl_if.sv | 15 +
 rtl/spi_pwm_cfg_ctrl.sv | 170 +++++++++++++++++
 tb/tb_spi_pwm_cfg_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_cfg_ctrl_if.sv
// SPI pin bundle between an external SPI master and spi_pwm_cfg_ctrl.
//   sclk : SPI clock, mode 0, asynchronous to the system clock
//   copi : serial data from master to slave, MSB first
//   ncs  : active-low chip select
//   cipo : serial data from slave to master (readback builds only; 0 otherwise)
// Modports: master drives sclk/copi/ncs and reads cipo; slave is the reverse.
interface spi_pwm_cfg_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI-slave configuration controller for pwm_peripheral.
// Receives 16-bit frames {rw, addr[6:0], data[7:0]} (MSB first, mode 0) and
// keeps the five 8-bit configuration registers that feed pwm_peripheral.
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   spi (slave)       : sclk/copi/ncs inputs (asynchronous), cipo output
//   en_reg_out_7_0    : register 0x00
//   en_reg_out_15_8   : register 0x01
//   en_reg_pwm_7_0    : register 0x02
//   en_reg_pwm_15_8   : register 0x03
//   pwm_duty_cycle    : register 0x04
//   cfg_update        : one-cycle pulse per committed write
//   frame_err         : one-cycle pulse when a frame had a bit count other than 16
//
// Parameter MAX_ADDR: highest accepted write/read address.
// Optional macro SPI_READBACK_EN: enables register readback on cipo for
// frames with rw = 0. Without it cipo is tied low and read frames are ignored.
module spi_pwm_cfg_ctrl #(
    parameter int MAX_ADDR = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_pwm_cfg_ctrl_if.slave    spi,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic                 cfg_update,
    output logic                 frame_err
);

    localparam int NUM_REGS = 5;

    // [0],[1] form the synchronizer, [2] is the delay flop for edge detection.
    logic [2:0] sclk_pipe_reg;
    logic [2:0] copi_pipe_reg;
    logic [2:0] ncs_pipe_reg;

    logic [4:0]  bit_cnt_reg;
    logic [15:0] shift_reg;
    logic [7:0]  cfg_reg [NUM_REGS];
    logic        cfg_update_reg;
    logic        frame_err_reg;

    logic        ncs_s;
    logic        ncs_rise;
    logic        ncs_fall;
    logic        sclk_rise;
    logic        copi_s;
    logic [15:0] shift_next;
    logic        addr_ok;
    logic        wr_commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe_reg <= 3'b000;
            copi_pipe_reg <= 3'b000;
            // Idle chip select is high; resetting to 1 avoids a false ncs rise
            // (and thus a spurious frame_err) right after reset.
            ncs_pipe_reg  <= 3'b111;
        end else begin
            sclk_pipe_reg <= {sclk_pipe_reg[1:0], spi.sclk};
            copi_pipe_reg <= {copi_pipe_reg[1:0], spi.copi};
            ncs_pipe_reg  <= {ncs_pipe_reg[1:0], spi.ncs};
        end
    end

    assign ncs_s     = ncs_pipe_reg[1];
    assign ncs_rise  =  ncs_pipe_reg[1] & ~ncs_pipe_reg[2];
    assign ncs_fall  = ~ncs_pipe_reg[1] &  ncs_pipe_reg[2];
    assign sclk_rise =  sclk_pipe_reg[1] & ~sclk_pipe_reg[2];
    // copi is taken from the delay stage: still inside its stability window
    // around the sclk edge, and it keeps every stage of the pipe in use.
    assign copi_s     = copi_pipe_reg[2];
    assign shift_next = {shift_reg[14:0], copi_s};

    // Frame receiver: bit counter saturates at 17 so over-long frames still
    // register as "not 16" at commit time.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg <= 5'd0;
            shift_reg   <= 16'h0000;
        end else if (ncs_fall) begin
            bit_cnt_reg <= 5'd0;
            shift_reg   <= 16'h0000;
        end else if (sclk_rise && !ncs_s) begin
            shift_reg <= shift_next;
            if (bit_cnt_reg != 5'd17) begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
        end
    end

    assign addr_ok   = (shift_reg[14:8] <= 7'(MAX_ADDR));
    assign wr_commit = ncs_rise && (bit_cnt_reg == 5'd16) && shift_reg[15] && addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_update_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            cfg_update_reg <= wr_commit;
            frame_err_reg  <= ncs_rise && (bit_cnt_reg != 5'd16);
        end
    end

    // Register bank; addresses between NUM_REGS and MAX_ADDR (if any) are
    // accepted but have no storage behind them.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
            always_ff @(posedge clk) begin
                if (rst) begin
                    cfg_reg[gi] <= 8'h00;
                end else if (wr_commit && (shift_reg[14:8] == 7'(gi))) begin
                    cfg_reg[gi] <= shift_reg[7:0];
                end
            end
        end
    endgenerate

    assign en_reg_out_7_0  = cfg_reg[0];
    assign en_reg_out_15_8 = cfg_reg[1];
    assign en_reg_pwm_7_0  = cfg_reg[2];
    assign en_reg_pwm_15_8 = cfg_reg[3];
    assign pwm_duty_cycle  = cfg_reg[4];
    assign cfg_update      = cfg_update_reg;
    assign frame_err       = frame_err_reg;

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic       rd_load;
    logic       rd_ok;
    logic [7:0] rd_data;
    logic [7:0] tx_reg;

    assign sclk_fall = ~sclk_pipe_reg[1] & sclk_pipe_reg[2];
    // On the 8th rising edge shift_next holds {rw, addr} in its low byte.
    assign rd_load   = sclk_rise && !ncs_s && (bit_cnt_reg == 5'd7);
    assign rd_ok     = !shift_next[7] && (shift_next[6:0] <= 7'(MAX_ADDR));

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next[6:0] == 7'(i)) begin
                rd_data = cfg_reg[i];
            end
        end
    end

    // The falling edge right after the load (count 8) must not shift, so the
    // MSB is still presented when the master samples frame bit 7 on the 9th
    // rising edge; shifting starts at the falling edge after that one.
    always_ff @(posedge clk) begin
        if (rst || ncs_fall) begin
            tx_reg <= 8'h00;
        end else if (rd_load) begin
            tx_reg <= rd_ok ? rd_data : 8'h00;
        end else if (sclk_fall && !ncs_s && (bit_cnt_reg >= 5'd9) && (bit_cnt_reg <= 5'd16)) begin
            tx_reg <= {tx_reg[6:0], 1'b0};
        end
    end

    assign spi.cipo = ~ncs_s & tx_reg[7];
`else
    assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
module tb_spi_pwm_cfg_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       cfg_update;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    logic [7:0] rx;

    spi_pwm_cfg_ctrl_if spi ();

    spi_pwm_cfg_ctrl #(.MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi.slave),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .cfg_update      (cfg_update),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (cfg_update === 1'b1) upd_cnt++;
        if (frame_err === 1'b1)  err_cnt++;
    end

    // Drives ncs low and shifts the low nbits of data MSB first, leaving ncs low.
    // cipo is captured just before rising edges 9..16 (frame bits 7..0).
    task automatic spi_bits(input logic [31:0] data, input int nbits);
        @(negedge clk);
        spi.ncs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi.copi = data[nbits-1-i];
            repeat (6) @(negedge clk);
            if (i >= 8 && i < 16) rx = {rx[6:0], spi.cipo};
            spi.sclk = 1'b1;
            repeat (6) @(negedge clk);
            spi.sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_end();
        @(negedge clk);
        spi.ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_write(input logic [15:0] frame);
        spi_bits({16'h0, frame}, 16);
        spi_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi.ncs = 1'b1; spi.sclk = 1'b0; spi.copi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0) begin
            bad++; $display("FAIL reset_regs got=%h exp=0", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
        end
        total++;
        if (upd_cnt !== 0 || err_cnt !== 0) begin
            bad++; $display("FAIL reset_pulses upd=%0d err=%0d exp=0/0", upd_cnt, err_cnt);
        end
        total++;
        if (spi.cipo !== 1'b0) begin
            bad++; $display("FAIL reset_cipo got=%b exp=0", spi.cipo);
        end
        $display("reset: regs=%h upd=%0d err=%0d", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, upd_cnt, err_cnt);
    endtask

    task automatic test_write_latency();
        int u0;
        u0 = upd_cnt;
        spi_bits(32'h8455, 16);
        @(negedge clk);
        spi.ncs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pwm_duty_cycle !== 8'h00 || cfg_update !== 1'b0) begin
            bad++; $display("FAIL lat_edge2 duty=%h upd=%b exp=00/0", pwm_duty_cycle, cfg_update);
        end
        @(posedge clk); #1;
        total++;
        if (pwm_duty_cycle !== 8'h55 || cfg_update !== 1'b1) begin
            bad++; $display("FAIL lat_edge3 duty=%h upd=%b exp=55/1", pwm_duty_cycle, cfg_update);
        end
        @(posedge clk); #1;
        total++;
        if (cfg_update !== 1'b0) begin
            bad++; $display("FAIL lat_edge4 upd=%b exp=0", cfg_update);
        end
        repeat (6) @(negedge clk);
        total++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8} !== 32'h0 || upd_cnt - u0 !== 1) begin
            bad++; $display("FAIL duty_only others=%h pulses=%0d exp=0/1", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, upd_cnt - u0);
        end
        $display("write 8455: duty=%h pulses=%0d", pwm_duty_cycle, upd_cnt - u0);
    endtask

    task automatic test_enables();
        int u0;
        u0 = upd_cnt;
        spi_write(16'h80F0);
        spi_write(16'h810F);
        spi_write(16'h82AA);
        spi_write(16'h8355);
        total++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8} !== 32'hF00FAA55 || upd_cnt - u0 !== 4) begin
            bad++; $display("FAIL enables got=%h pulses=%0d exp=f00faa55/4", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, upd_cnt - u0);
        end
        $display("enables: %h pulses=%0d", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8}, upd_cnt - u0);
        u0 = upd_cnt;
        spi_write(16'h9012);
        total++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'hF00FAA5555 || upd_cnt - u0 !== 0) begin
            bad++; $display("FAIL bad_addr regs=%h pulses=%0d exp=f00faa5555/0", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, upd_cnt - u0);
        end
        $display("write 9012: pulses=%0d", upd_cnt - u0);
    endtask

    task automatic test_bad_length();
        int e0;
        int u0;
        e0 = err_cnt;
        u0 = upd_cnt;
        spi_bits(32'h0000403B, 15);   // top 15 bits of 0x8077
        spi_end();
        spi_bits(32'h000100EF, 17);   // 0x8077 plus one extra bit
        spi_end();
        total++;
        if (en_reg_out_7_0 !== 8'hF0 || err_cnt - e0 !== 2 || upd_cnt - u0 !== 0) begin
            bad++; $display("FAIL bad_len reg=%h err=%0d upd=%0d exp=f0/2/0", en_reg_out_7_0, err_cnt - e0, upd_cnt - u0);
        end
        e0 = err_cnt;
        @(negedge clk); spi.ncs = 1'b0;
        repeat (6) @(negedge clk);
        spi_end();
        total++;
        if (err_cnt - e0 !== 1 || upd_cnt - u0 !== 0) begin
            bad++; $display("FAIL empty_frame err=%0d upd=%0d exp=1/0", err_cnt - e0, upd_cnt - u0);
        end
        spi_write(16'h8001);
        total++;
        if (en_reg_out_7_0 !== 8'h01) begin
            bad++; $display("FAIL after_err got=%h exp=01", en_reg_out_7_0);
        end
        $display("bad length: reg0=%h errs=%0d", en_reg_out_7_0, err_cnt);
    endtask

    task automatic test_back_to_back();
        int u0;
        u0 = upd_cnt;
        spi_bits(32'h8011, 16);
        @(negedge clk); spi.ncs = 1'b1;
        repeat (5) @(negedge clk);
        spi_bits(32'h8122, 16);
        spi_end();
        total++;
        if (en_reg_out_7_0 !== 8'h11 || en_reg_out_15_8 !== 8'h22 || upd_cnt - u0 !== 2) begin
            bad++; $display("FAIL back_to_back r0=%h r1=%h pulses=%0d exp=11/22/2", en_reg_out_7_0, en_reg_out_15_8, upd_cnt - u0);
        end
        $display("back to back: r0=%h r1=%h pulses=%0d", en_reg_out_7_0, en_reg_out_15_8, upd_cnt - u0);
    endtask

    task automatic test_readback();
        int u0;
        int e0;
        logic [7:0] exp_rx;
`ifdef SPI_READBACK_EN
        exp_rx = 8'hC3;
`else
        exp_rx = 8'h00;
`endif
        spi_write(16'h82C3);
        u0 = upd_cnt;
        e0 = err_cnt;
        rx = 8'hxx;
        spi_bits(32'h0200, 16);
        spi_end();
        total++;
        if (rx !== exp_rx) begin
            bad++; $display("FAIL readback cipo=%h exp=%h", rx, exp_rx);
        end
        total++;
        if (en_reg_pwm_7_0 !== 8'hC3 || upd_cnt - u0 !== 0 || err_cnt - e0 !== 0) begin
            bad++; $display("FAIL read_side reg=%h upd=%0d err=%0d exp=c3/0/0", en_reg_pwm_7_0, upd_cnt - u0, err_cnt - e0);
        end
        total++;
        if (spi.cipo !== 1'b0) begin
            bad++; $display("FAIL cipo_idle got=%b exp=0", spi.cipo);
        end
        $display("read 0200: cipo bits=%h reg2=%h", rx, en_reg_pwm_7_0);
    endtask

    task automatic test_mid_reset();
        int e0;
        spi_bits(32'h213, 10);        // first 10 bits of 0x84FF
        @(negedge clk);
        rst = 1'b1;
        spi.ncs = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        e0 = err_cnt;
        repeat (10) @(negedge clk);
        total++;
        if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0 || cfg_update !== 1'b0) begin
            bad++; $display("FAIL mid_reset regs=%h upd=%b exp=0", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle}, cfg_update);
        end
        spi_write(16'h8433);
        total++;
        if (pwm_duty_cycle !== 8'h33 || err_cnt - e0 !== 0) begin
            bad++; $display("FAIL post_reset duty=%h err=%0d exp=33/0", pwm_duty_cycle, err_cnt - e0);
        end
        $display("mid-frame reset: duty=%h", pwm_duty_cycle);
    endtask

    initial begin
        rx = 8'h00;
        test_reset();
        test_write_latency();
        test_enables();
        test_bad_length();
        test_back_to_back();
        test_readback();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
